// File: rtl/sar_sequencer_pkg.sv
// sar_seq_pkg: shared state encoding and sizing helpers
// for the SAR burst-averaging sequencer.
package sar_seq_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    ISSUE,
    WAIT,
    ACC,
    DONE
  } state_e;

  localparam int SETTLE_CYC = 3;

  function automatic int ACC_W(input int nstep,
                               input int max_log2);
    return nstep + max_log2;
  endfunction

endpackage

// File: rtl/sar_sequencer_if.sv
// Request/result bus and SAR ADC toggle bus.
// master drives requests / SOC, slave answers.
interface sar_req_if #(
  parameter int NSTEP = 10,
  parameter int AVG_W = 3
);
  logic             req_start;
  logic [AVG_W-1:0] req_avg_log2;
  logic             busy;
  logic             res_valid;
  logic [NSTEP-1:0] res_code;
  logic             res_err;
  logic             res_warn;
  logic             res_timeout;

  modport master (
    output req_start, req_avg_log2,
    input  busy, res_valid, res_code,
    input  res_err, res_warn, res_timeout
  );

  modport slave (
    input  req_start, req_avg_log2,
    output busy, res_valid, res_code,
    output res_err, res_warn, res_timeout
  );
endinterface

interface sar_adc_if #(
  parameter int NSTEP = 10
);
  logic             sar_soc;
  logic             sar_eoc;
  logic             sar_err;
  logic             sar_warn;
  logic [NSTEP-1:0] sar_code;

  modport master (
    output sar_soc,
    input  sar_eoc, sar_err, sar_warn, sar_code
  );

  modport slave (
    input  sar_soc,
    output sar_eoc, sar_err, sar_warn, sar_code
  );
endinterface

// File: rtl/sar_sequencer_det.sv
// toggle_event_det: 2-flop synchroniser plus history
// flop; any level change becomes a one-cycle event.
module toggle_event_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mask_i,
  input  logic tog_i,
  output logic ev_o
);

  logic s1_q, s2_q, hist_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= tog_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  // mask hides the level the line had before reset
  assign ev_o = (s2_q ^ hist_q) & ~mask_i;

endmodule

// File: rtl/sar_sequencer.sv
// sar_sequencer: one start -> 2^n SAR conversions,
// averaged result. Option: SAR_SEQ_TIMEOUT_EN.
module sar_sequencer
  import sar_seq_pkg::*;
#(
  parameter int NSTEP        = 10,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int AVG_W        = 3,
  parameter int TIMEOUT_CYC  = 255
) (
  input logic       f100m_clk,
  input logic       rstb,
  sar_req_if.slave  req,
  sar_adc_if.master adc
);

  localparam int AW = ACC_W(NSTEP, MAX_AVG_LOG2);
  localparam int NW = $clog2(MAX_AVG_LOG2 + 1);

  state_e                  state_q;
  logic [1:0]              settle_q;
  logic [NW-1:0]           n_q;
  logic [AW-1:0]           acc_q;
  logic [MAX_AVG_LOG2-1:0] cnt_q;
  logic [MAX_AVG_LOG2-1:0] last_w;
  logic                    err_q, err_d;
  logic                    warn_q, warn_d;
  logic                    soc_q, busy_q, valid_q;
  logic [NSTEP-1:0]        code_q;
  logic                    res_err_q, res_warn_q;
  logic                    eoc_ev, err_ev, warn_ev;
  logic                    settle_w;

`ifdef SAR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_res_q;
  assign req.res_timeout = tmo_res_q;
`else
  // feature disabled: constant 0
  assign req.res_timeout = (TIMEOUT_CYC < 0);
`endif

  assign settle_w = (state_q == SETTLE);

  toggle_event_det u_eoc (
    .clk_i (f100m_clk),
    .rst_ni(rstb),
    .mask_i(settle_w),
    .tog_i (adc.sar_eoc),
    .ev_o  (eoc_ev)
  );

  toggle_event_det u_err (
    .clk_i (f100m_clk),
    .rst_ni(rstb),
    .mask_i(settle_w),
    .tog_i (adc.sar_err),
    .ev_o  (err_ev)
  );

  toggle_event_det u_warn (
    .clk_i (f100m_clk),
    .rst_ni(rstb),
    .mask_i(settle_w),
    .tog_i (adc.sar_warn),
    .ev_o  (warn_ev)
  );

  assign last_w = MAX_AVG_LOG2'((1 << n_q) - 1);
  assign err_d  = err_q | (err_ev & (state_q != IDLE));
  assign warn_d = warn_q | (warn_ev & (state_q != IDLE));

  always_ff @(posedge f100m_clk) begin
    if (!rstb) begin
      state_q    <= SETTLE;
      settle_q   <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      warn_q     <= 1'b0;
      soc_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      res_err_q  <= 1'b0;
      res_warn_q <= 1'b0;
`ifdef SAR_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
      tmo_res_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= err_d;
      warn_q  <= warn_d;
      unique case (state_q)
        SETTLE: begin
          if (settle_q == 2'(SETTLE_CYC - 1))
            state_q <= IDLE;
          else
            settle_q <= settle_q + 2'd1;
        end
        IDLE: begin
          if (req.req_start) begin
            if (req.req_avg_log2 >
                AVG_W'(MAX_AVG_LOG2))
              n_q <= NW'(MAX_AVG_LOG2);
            else
              n_q <= NW'(req.req_avg_log2);
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            warn_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          soc_q   <= ~soc_q;
          state_q <= WAIT;
`ifdef SAR_SEQ_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        WAIT: begin
          if (eoc_ev) begin
            acc_q   <= acc_q + AW'(adc.sar_code);
            state_q <= ACC;
          end
`ifdef SAR_SEQ_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            code_q     <= '0;
            res_err_q  <= err_d;
            res_warn_q <= warn_d;
            tmo_res_q  <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        ACC: begin
          if (cnt_q == last_w) begin
            code_q     <= NSTEP'(acc_q >> n_q);
            res_err_q  <= err_d;
            res_warn_q <= warn_d;
            valid_q    <= 1'b1;
            state_q    <= DONE;
`ifdef SAR_SEQ_TIMEOUT_EN
            tmo_res_q  <= 1'b0;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign req.busy      = busy_q;
  assign req.res_valid = valid_q;
  assign req.res_code  = code_q;
  assign req.res_err   = res_err_q;
  assign req.res_warn  = res_warn_q;
  assign adc.sar_soc   = soc_q;

endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
Initiator on the SAR ADC conversion interface. It turns a single start request into a burst of 2^n conversions, accumulates the returned codes and delivers one averaged result with error/warning flags. It sits in the digital core between register/control logic and the SAR controller's toggle-based SOC/EOC/ERR/WARN interface. It drives sar_soc and consumes sar_eoc, sar_err, sar_warn and sar_code.

Parameters:
NSTEP, 10, width of sar_code and res_code
MAX_AVG_LOG2, 4, largest averaging exponent; burst length is at most 16
AVG_W, 3, width of req_avg_log2
TIMEOUT_CYC, 255, WAIT-state cycle limit (used only with SAR_SEQ_TIMEOUT_EN)

Ports:
f100m_clk  in  1  system clock
rstb  in  1  synchronous active-low reset
req_start  in  1  one-cycle start pulse
req_avg_log2  in  AVG_W  averaging exponent n, sampled with req_start
busy  out  1  burst in progress
res_valid  out  1  one-cycle result strobe
res_code  out  NSTEP  averaged code
res_err  out  1  sticky: an ERR toggle was seen during the burst
res_warn  out  1  sticky: a WARN toggle was seen during the burst
res_timeout  out  1  burst aborted by timeout (tied 0 without SAR_SEQ_TIMEOUT_EN)
sar_soc  out  1  start-of-conversion toggle; one edge per conversion
sar_eoc  in  1  end-of-conversion toggle; one edge per completed conversion
sar_err  in  1  error toggle
sar_warn  in  1  warning toggle
sar_code  in  NSTEP  conversion result; stable from the EOC edge until the next SOC

Behaviour:
- Reset: f100m_clk, synchronous, rstb=0 at a rising edge. All outputs are 0 and all state clears, including sar_soc=0 and the sync flops. A reset asserted mid-burst aborts the burst silently; no res_valid is produced.
- Input conditioning: sar_eoc, sar_err and sar_warn each pass through 2 sync flops plus 1 history flop. An event is (stage2 XOR history), so detection latency is 3 cycles from the raw edge.
- States:
  - SETTLE: entered after reset; lasts 3 cycles; events masked; history loaded from stage2; then IDLE.
  - IDLE: waits for req_start.
  - ISSUE: one cycle; toggles sar_soc.
  - WAIT: waits for an eoc event.
  - ACC: one cycle; adds the code and decides whether to continue.
  - DONE: one cycle; asserts res_valid.
- Transitions:
  - IDLE, req_start=1: latch n = min(req_avg_log2, MAX_AVG_LOG2); clear acc, cnt, err and warn; go to ISSUE. busy=1 from the following cycle.
  - ISSUE -> WAIT after the sar_soc toggle.
  - WAIT, eoc event: capture sar_code into acc (acc += zero-extended sar_code); go to ACC.
  - ACC: if cnt == 2^n-1, go to DONE; else cnt++ and go to ISSUE. A new SOC toggle therefore follows 2 cycles after EOC detection.
  - DONE: res_valid=1; res_code = acc >> n (truncating); res_err and res_warn carry the sticky values; return to IDLE with busy=0.
- res_code, res_err, res_warn and res_timeout hold their value until the next DONE.
- Widths: acc is NSTEP+MAX_AVG_LOG2 bits, so there is no overflow; cnt is MAX_AVG_LOG2 bits.
- n=0 gives a single conversion, and res_code equals that conversion's sar_code.
- req_start while busy is ignored; it is not queued.
- err and warn events set the sticky flags in any non-IDLE state. The burst continues.
- An eoc event outside WAIT (spurious) is dropped and does not advance state.
- An eoc event and an err event in the same cycle are both honoured.

Optional Feature:
SAR_SEQ_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - When it reaches TIMEOUT_CYC, go to DONE with res_timeout=1 and res_code=0, while res_err and res_warn keep their sticky values.
  - sar_soc is left at its current value. The next burst proceeds normally, but an eoc event arriving late is dropped if it lands outside WAIT.
- Undefined: there is no counter and res_timeout is tied 0; WAIT can last indefinitely.

Decomposition:
- Package sar_seq_pkg:
  - state enum (SETTLE, IDLE, ISSUE, WAIT, ACC, DONE)
  - SETTLE_CYC=3
  - ACC_W function of NSTEP and MAX_AVG_LOG2
- Sub-module toggle_event_det:
  - 2-flop sync + history flop + XOR
  - masked history load during SETTLE
  - instantiated three times: eoc, err, warn

Test Plan:
- Reset, then req_start with n=0; the ADC model answers with an EOC toggle 12 cycles after SOC, with code 0x2A5 -> one sar_soc edge; res_valid 1 cycle; res_code=0x2A5; res_err=0.
- n=2, codes 100, 101, 102, 104 -> 4 SOC toggles, each 2 cycles after EOC detection; res_code=101 (407>>2).
- n=7 with MAX_AVG_LOG2=4, all codes 0x3FF -> burst clamped to 16 conversions; res_code=0x3FF with no overflow.
- ERR toggle during the 2nd conversion of an n=1 burst -> burst completes; res_err=1; a following clean burst gives res_err=0.
- Spurious EOC toggle in IDLE, and req_start asserted while busy -> no state change and no extra SOC toggle.
- rstb=0 mid-WAIT, then an EOC toggle arrives within 3 cycles of release -> masked by SETTLE; no res_valid. With SAR_SEQ_TIMEOUT_EN and no EOC, res_timeout=1 after 255 WAIT cycles.
